// File: rtl/multdiv_seq_unit.sv
// multdiv_seq_unit
//   Sequential signed multiply/divide unit with a valid/ready handshake.
//   It accepts one op, iterates on operand magnitudes in the background and
//   holds the signed result until writeback acknowledges it.
//
//   Ports
//     clock, reset      rising-edge clock, asynchronous active-high reset
//     in_valid/in_ready op handshake; in_is_div, in_a, in_b, in_tag carry the op
//     kill              abandons an op in RUN or FIX
//     busy              op in flight (RUN or FIX)
//     out_valid/out_ack result handshake; out_result, out_exception,
//                       out_tag, out_is_div describe the held result
module multdiv_seq_unit #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_is_div,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             kill,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ack,
  output logic [WIDTH-1:0] out_result,
  output logic             out_exception,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_is_div
);

  localparam int CNT_W = $clog2(WIDTH + 2);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     count_q;
  logic [WIDTH-1:0]     mag_a_q, mag_b_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic                 neg_q, div_q, b_zero_q;
  logic [TAG_W-1:0]     tag_q;

  logic                 accept;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;
  logic [2*WIDTH-1:0]   div_shift;
  logic [WIDTH-1:0]     div_hi;
  logic [2*WIDTH-1:0]   div_next;
  logic [2*WIDTH-1:0]   prod_s;
  logic [WIDTH-1:0]     quot_s;
  logic                 mul_exc, div_exc;

  assign in_ready  = (state_q == IDLE) | ((state_q == DONE) & out_ack);
  assign accept    = in_valid & in_ready & ~kill;
  assign busy      = (state_q == RUN) | (state_q == FIX);
  assign out_valid = (state_q == DONE);

  // Magnitudes are unsigned, so the most negative value maps to 2^(WIDTH-1)
  // without overflow.
  assign a_mag = in_a[WIDTH-1] ? (WIDTH'(0) - in_a) : in_a;
  assign b_mag = in_b[WIDTH-1] ? (WIDTH'(0) - in_b) : in_b;

  // Multiply step: conditionally add the multiplicand into the upper half,
  // then shift right; the carry moves into the top bit.
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                    (acc_q[0] ? {1'b0, mag_a_q} : {(WIDTH+1){1'b0}});
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // Restoring divide step. The partial remainder stays below the divisor
  // magnitude (at most 2^(WIDTH-1)), so after the shift it still fits in
  // WIDTH bits.
  assign div_shift = {acc_q[2*WIDTH-2:0], 1'b0};
  assign div_hi    = div_shift[2*WIDTH-1:WIDTH];
  assign div_next  = (div_hi >= mag_b_q) ?
                     {div_hi - mag_b_q, div_shift[WIDTH-1:1], 1'b1} : div_shift;

  // Sign fix-up and exception detection used in FIX
  assign prod_s  = neg_q ? ((2*WIDTH)'(0) - acc_q) : acc_q;
  assign mul_exc = ~((&prod_s[2*WIDTH-1:WIDTH-1]) | ~(|prod_s[2*WIDTH-1:WIDTH-1]));
  assign quot_s  = neg_q ? (WIDTH'(0) - acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
  assign div_exc = b_zero_q | (~neg_q & acc_q[WIDTH-1]);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // RUN spends its first cycle priming the accumulator from the latched
  // magnitudes, then does WIDTH iterations. This gives the fixed accept-to-valid
  // latency of WIDTH+2 edges.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = RUN;
      RUN: begin
        if (kill)                           state_d = IDLE;
        else if (count_q == CNT_W'(WIDTH))  state_d = FIX;
      end
      FIX:  state_d = kill ? IDLE : DONE;
      DONE: if (out_ack) state_d = accept ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q       <= '0;
      mag_a_q       <= '0;
      mag_b_q       <= '0;
      acc_q         <= '0;
      neg_q         <= 1'b0;
      div_q         <= 1'b0;
      b_zero_q      <= 1'b0;
      tag_q         <= '0;
      out_result    <= '0;
      out_exception <= 1'b0;
      out_tag       <= '0;
      out_is_div    <= 1'b0;
    end else begin
      if (accept) begin
        mag_a_q  <= a_mag;
        mag_b_q  <= b_mag;
        neg_q    <= in_a[WIDTH-1] ^ in_b[WIDTH-1];
        div_q    <= in_is_div;
        b_zero_q <= (in_b == '0);
        tag_q    <= in_tag;
        count_q  <= '0;
      end else if ((state_q == RUN) && !kill) begin
        if (count_q == '0)
          acc_q <= div_q ? {{WIDTH{1'b0}}, mag_a_q} : {{WIDTH{1'b0}}, mag_b_q};
        else
          acc_q <= div_q ? div_next : mul_next;
        count_q <= count_q + 1'b1;
      end else if ((state_q == FIX) && !kill) begin
        out_tag    <= tag_q;
        out_is_div <= div_q;
        if (div_q) begin
          out_result    <= b_zero_q ? '0 : quot_s;
          out_exception <= div_exc;
        end else begin
          out_result    <= prod_s[WIDTH-1:0];
          out_exception <= mul_exc;
        end
      end
    end
  end

endmodule
